// File: rtl/vr_vc_converter.sv
// Valid/ready to valid/credit transmitter: 2-entry skid FIFO, credit counter, one word per credit.
// Optional credit-overflow flag and send-without-credit assertion under VR_VC_CREDIT_CHECK_EN.
module vr_vc_converter #(
  parameter int DATA_WIDTH = 8,
  parameter int CREDIT_NUM = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_credit_i
`ifdef VR_VC_CREDIT_CHECK_EN
  ,
  output logic                  credit_err_o
`endif
);

  localparam int CW = $clog2(CREDIT_NUM) + 1;
  localparam logic [CW-1:0] CREDIT_MAX = CW'(CREDIT_NUM);

  logic                  wr_ptr_reg;
  logic                  rd_ptr_reg;
  logic [1:0]            fill_reg;
  logic [1:0]            fill_next;
  logic [CW-1:0]         credit_cnt_reg;
  logic [CW-1:0]         credit_cnt_next;
  logic                  s_ready_reg;
  logic                  m_valid_reg;
  logic [DATA_WIDTH-1:0] m_data_reg;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  push;
  logic                  send;
  logic                  credit_overflow;

  assign push = s_valid_i & s_ready_reg;
  assign send = (fill_reg != 2'd0) & (credit_cnt_reg != '0);
  assign credit_overflow = m_credit_i & ~send & (credit_cnt_reg == CREDIT_MAX);

  // Payload storage needs no reset; occupancy is tracked by fill_reg.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      logic [DATA_WIDTH-1:0] entry_reg;
      always_ff @(posedge clk) begin
        if (push && (wr_ptr_reg == 1'(gi))) begin
          entry_reg <= s_data_i;
        end
      end
    end
  endgenerate

  assign head_data = rd_ptr_reg ? g_slot[1].entry_reg : g_slot[0].entry_reg;

  always_comb begin
    fill_next = fill_reg;
    if (push && !send) begin
      fill_next = fill_reg + 2'd1;
    end else if (!push && send) begin
      fill_next = fill_reg - 2'd1;
    end
  end

  // A credit returned while already full and idle is dropped (saturation).
  always_comb begin
    credit_cnt_next = credit_cnt_reg;
    if (m_credit_i && !send) begin
      if (!credit_overflow) begin
        credit_cnt_next = credit_cnt_reg + 1'b1;
      end
    end else if (!m_credit_i && send) begin
      credit_cnt_next = credit_cnt_reg - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg     <= 1'b0;
      rd_ptr_reg     <= 1'b0;
      fill_reg       <= 2'd0;
      credit_cnt_reg <= '0;
      s_ready_reg    <= 1'b0;
      m_valid_reg    <= 1'b0;
      m_data_reg     <= '0;
    end else begin
      fill_reg       <= fill_next;
      credit_cnt_reg <= credit_cnt_next;
      s_ready_reg    <= (fill_next != 2'd2);
      m_valid_reg    <= send;
      if (push) begin
        wr_ptr_reg <= ~wr_ptr_reg;
      end
      if (send) begin
        rd_ptr_reg <= ~rd_ptr_reg;
        m_data_reg <= head_data;
      end
    end
  end

  assign s_ready_o = s_ready_reg;
  assign m_valid_o = m_valid_reg;
  assign m_data_o  = m_data_reg;

`ifdef VR_VC_CREDIT_CHECK_EN
  logic credit_err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_err_reg <= 1'b0;
    end else if (credit_overflow) begin
      credit_err_reg <= 1'b1;
    end
  end

  assign credit_err_o = credit_err_reg;

  // A word must never leave without a credit in hand.
  send_has_credit: assert property (@(posedge clk) disable iff (!rst_n)
    send |-> (credit_cnt_reg != '0));
`endif

endmodule

// File: tb/tb_vr_vc_converter.sv
// Directed testbench for vr_vc_converter: latency, credit exhaustion, streaming, saturation, async reset.
// Define VR_VC_CREDIT_CHECK_EN to also check the sticky credit_err_o flag.
module tb_vr_vc_converter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_credit;
`ifdef VR_VC_CREDIT_CHECK_EN
  logic       credit_err;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  vr_vc_converter #(
    .DATA_WIDTH(8),
    .CREDIT_NUM(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_data_i  (s_data),
    .s_valid_i (s_valid),
    .s_ready_o (s_ready),
    .m_data_o  (m_data),
    .m_valid_o (m_valid),
    .m_credit_i(m_credit)
`ifdef VR_VC_CREDIT_CHECK_EN
    ,
    .credit_err_o(credit_err)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    s_valid  = 1'b0;
    m_credit = 1'b0;
    s_data   = 8'h00;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    s_valid  = 1'b0;
    m_credit = 1'b0;
    s_data   = 8'h00;
    #1;
    total_cnt++; if (s_ready !== 1'b0) $display("FAIL reset_ready: got %b expected 0", s_ready); else pass_cnt++;
    total_cnt++; if (m_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", m_valid); else pass_cnt++;
    total_cnt++; if (m_data !== 8'h00) $display("FAIL reset_data: got %h expected 00", m_data); else pass_cnt++;
    step();
    rst_n = 1'b1;
    step();
    total_cnt++; if (s_ready !== 1'b1) $display("FAIL reset_release_ready: got %b expected 1", s_ready); else pass_cnt++;
    $display("test_reset done");
  endtask

  task automatic test_single();
    do_reset();
    m_credit = 1'b1;
    step();
    step();
    m_credit = 1'b0;
    s_valid  = 1'b1;
    s_data   = 8'hA1;
    step();
    total_cnt++; if (m_valid !== 1'b0) $display("FAIL single_early: got %b expected 0", m_valid); else pass_cnt++;
    s_valid = 1'b0;
    step();
    total_cnt++; if (m_valid !== 1'b1) $display("FAIL single_valid: got %b expected 1", m_valid); else pass_cnt++;
    total_cnt++; if (m_data !== 8'hA1) $display("FAIL single_data: got %h expected a1", m_data); else pass_cnt++;
    step();
    total_cnt++; if (m_valid !== 1'b0) $display("FAIL single_pulse: got %b expected 0", m_valid); else pass_cnt++;
    total_cnt++; if (m_data !== 8'hA1) $display("FAIL single_hold: got %h expected a1", m_data); else pass_cnt++;
    // one credit left: B2 goes, C3 must wait
    s_valid = 1'b1;
    s_data  = 8'hB2;
    step();
    s_valid = 1'b0;
    step();
    total_cnt++; if (m_data !== 8'hB2 || m_valid !== 1'b1) $display("FAIL single_second: got %b/%h expected 1/b2", m_valid, m_data); else pass_cnt++;
    s_valid = 1'b1;
    s_data  = 8'hC3;
    step();
    s_valid = 1'b0;
    step();
    total_cnt++; if (m_valid !== 1'b0) $display("FAIL single_no_credit: got %b expected 0", m_valid); else pass_cnt++;
    m_credit = 1'b1;
    step();
    m_credit = 1'b0;
    total_cnt++; if (m_valid !== 1'b0) $display("FAIL single_no_bypass: got %b expected 0", m_valid); else pass_cnt++;
    step();
    total_cnt++; if (m_data !== 8'hC3 || m_valid !== 1'b1) $display("FAIL single_third: got %b/%h expected 1/c3", m_valid, m_data); else pass_cnt++;
    $display("test_single done");
  endtask

  task automatic test_exhaust();
    do_reset();
    s_valid = 1'b1;
    s_data  = 8'h11;
    step();
    total_cnt++; if (s_ready !== 1'b1) $display("FAIL exhaust_ready1: got %b expected 1", s_ready); else pass_cnt++;
    s_data = 8'h22;
    step();
    total_cnt++; if (s_ready !== 1'b0) $display("FAIL exhaust_full: got %b expected 0", s_ready); else pass_cnt++;
    s_data = 8'h33;
    step();
    total_cnt++; if (s_ready !== 1'b0) $display("FAIL exhaust_full_hold: got %b expected 0", s_ready); else pass_cnt++;
    total_cnt++; if (m_valid !== 1'b0) $display("FAIL exhaust_no_send: got %b expected 0", m_valid); else pass_cnt++;
    m_credit = 1'b1;
    step();
    m_credit = 1'b0;
    total_cnt++; if (m_valid !== 1'b0) $display("FAIL exhaust_no_bypass: got %b expected 0", m_valid); else pass_cnt++;
    step();
    total_cnt++; if (m_data !== 8'h11 || m_valid !== 1'b1) $display("FAIL exhaust_first: got %b/%h expected 1/11", m_valid, m_data); else pass_cnt++;
    total_cnt++; if (s_ready !== 1'b1) $display("FAIL exhaust_ready_back: got %b expected 1", s_ready); else pass_cnt++;
    step();
    s_valid = 1'b0;
    total_cnt++; if (m_valid !== 1'b0) $display("FAIL exhaust_only_one: got %b expected 0", m_valid); else pass_cnt++;
    total_cnt++; if (s_ready !== 1'b0) $display("FAIL exhaust_refull: got %b expected 0", s_ready); else pass_cnt++;
    m_credit = 1'b1;
    step();
    step();
    m_credit = 1'b0;
    total_cnt++; if (m_data !== 8'h22 || m_valid !== 1'b1) $display("FAIL exhaust_22: got %b/%h expected 1/22", m_valid, m_data); else pass_cnt++;
    step();
    total_cnt++; if (m_data !== 8'h33 || m_valid !== 1'b1) $display("FAIL exhaust_33: got %b/%h expected 1/33", m_valid, m_data); else pass_cnt++;
    step();
    total_cnt++; if (m_valid !== 1'b0) $display("FAIL exhaust_drain: got %b expected 0", m_valid); else pass_cnt++;
    $display("test_exhaust done");
  endtask

  task automatic test_stream();
    int  idx    = 0;
    int  sent   = 0;
    logic prev_v = 1'b0;
    logic pushed;
    do_reset();
    m_credit = 1'b1;
    for (int c = 0; c < 20; c++) begin
      s_valid = (idx < 8);
      s_data  = 8'(idx + 1);
      pushed  = s_valid && s_ready;
      step();
      if (pushed) idx++;
      if (m_valid) begin
        $display("stream word %0d: data %h", sent, m_data);
        total_cnt++; if (m_data !== 8'(sent + 1)) $display("FAIL stream_data: got %h expected %h", m_data, 8'(sent + 1)); else pass_cnt++;
        if (sent > 0) begin
          total_cnt++; if (prev_v !== 1'b1) $display("FAIL stream_bubble: got %b expected 1", prev_v); else pass_cnt++;
        end
        sent++;
      end
      prev_v = m_valid;
    end
    m_credit = 1'b0;
    s_valid  = 1'b0;
    total_cnt++; if (sent != 8) $display("FAIL stream_count: got %0d expected 8", sent); else pass_cnt++;
    $display("test_stream done");
  endtask

  task automatic test_credit_send_overlap();
    do_reset();
    m_credit = 1'b1;
    step();
    m_credit = 1'b0;
    s_valid  = 1'b1;
    s_data   = 8'hAA;
    step();
    s_data   = 8'hBB;
    m_credit = 1'b1;
    step();
    total_cnt++; if (m_data !== 8'hAA || m_valid !== 1'b1) $display("FAIL overlap_first: got %b/%h expected 1/aa", m_valid, m_data); else pass_cnt++;
    s_valid  = 1'b0;
    m_credit = 1'b0;
    step();
    total_cnt++; if (m_data !== 8'hBB || m_valid !== 1'b1) $display("FAIL overlap_second: got %b/%h expected 1/bb", m_valid, m_data); else pass_cnt++;
    step();
    total_cnt++; if (m_valid !== 1'b0) $display("FAIL overlap_end: got %b expected 0", m_valid); else pass_cnt++;
    $display("test_credit_send_overlap done");
  endtask

  task automatic test_saturation();
    int pulses = 0;
    do_reset();
    m_credit = 1'b1;
    step();
    step();
`ifdef VR_VC_CREDIT_CHECK_EN
    total_cnt++; if (credit_err !== 1'b0) $display("FAIL sat_err_early: got %b expected 0", credit_err); else pass_cnt++;
`endif
    step();
    m_credit = 1'b0;
`ifdef VR_VC_CREDIT_CHECK_EN
    total_cnt++; if (credit_err !== 1'b1) $display("FAIL sat_err_set: got %b expected 1", credit_err); else pass_cnt++;
`endif
    for (int c = 0; c < 8; c++) begin
      s_valid = (c < 3);
      s_data  = 8'(8'h51 + c);
      step();
      if (m_valid) pulses++;
    end
    s_valid = 1'b0;
    total_cnt++; if (pulses != 2) $display("FAIL sat_sends: got %0d expected 2", pulses); else pass_cnt++;
`ifdef VR_VC_CREDIT_CHECK_EN
    total_cnt++; if (credit_err !== 1'b1) $display("FAIL sat_err_sticky: got %b expected 1", credit_err); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (credit_err !== 1'b0) $display("FAIL sat_err_reset: got %b expected 0", credit_err); else pass_cnt++;
    step();
    rst_n = 1'b1;
    step();
`endif
    $display("test_saturation done");
  endtask

  task automatic test_async_reset();
    int pulses = 0;
    do_reset();
    s_valid = 1'b1;
    s_data  = 8'h61;
    step();
    s_data = 8'h62;
    step();
    s_valid  = 1'b0;
    m_credit = 1'b1;
    step();
    step();
    m_credit = 1'b0;
    total_cnt++; if (m_data !== 8'h61 || m_valid !== 1'b1) $display("FAIL arst_pre: got %b/%h expected 1/61", m_valid, m_data); else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (m_valid !== 1'b0) $display("FAIL arst_valid: got %b expected 0", m_valid); else pass_cnt++;
    total_cnt++; if (s_ready !== 1'b0) $display("FAIL arst_ready: got %b expected 0", s_ready); else pass_cnt++;
    total_cnt++; if (m_data !== 8'h00) $display("FAIL arst_data: got %h expected 00", m_data); else pass_cnt++;
    step();
    rst_n = 1'b1;
    step();
    total_cnt++; if (s_ready !== 1'b1) $display("FAIL arst_release_ready: got %b expected 1", s_ready); else pass_cnt++;
    s_valid = 1'b1;
    s_data  = 8'h70;
    step();
    s_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (m_valid) pulses++;
    end
    total_cnt++; if (pulses != 0) $display("FAIL arst_credit_forgotten: got %0d expected 0", pulses); else pass_cnt++;
    m_credit = 1'b1;
    step();
    m_credit = 1'b0;
    step();
    total_cnt++; if (m_data !== 8'h70 || m_valid !== 1'b1) $display("FAIL arst_fifo_cleared: got %b/%h expected 1/70", m_valid, m_data); else pass_cnt++;
    $display("test_async_reset done");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_exhaust();
    test_stream();
    test_credit_send_overlap();
    test_saturation();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/vr_vc_converter.md
Name: vr_vc_converter

Overview:
- Transmitter end of the link-level valid/credit protocol: accepts words on a valid/ready interface and forwards them on a valid/credit interface.
- Tracks the credits granted by the downstream valid/credit receiver, which drives a one-cycle credit pulse per free buffer slot, CREDIT_NUM pulses after reset.
- Buffers input words in a 2-entry skid FIFO and sends one word per cycle while credits remain.
- Sits at the upstream end of every credit-based hop in the interconnect.

Parameters:
- DATA_WIDTH, 8, payload width in bits.
- CREDIT_NUM, 2, maximum outstanding credits; must equal the receiver buffer depth; ≥1.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- s_data_i  input  DATA_WIDTH  valid/ready payload.
- s_valid_i  input  1  upstream word valid.
- s_ready_o  output  1  converter can accept a word.
- m_data_o  output  DATA_WIDTH  valid/credit payload.
- m_valid_o  output  1  one-cycle pulse per word sent downstream.
- m_credit_i  input  1  one-cycle credit-return pulse from the receiver.
- credit_err_o  output  1  sticky credit-overflow flag; exists only with VR_VC_CREDIT_CHECK_EN.

Behaviour:
- Reset (asserted asynchronously, released synchronously to clk):
  - skid FIFO emptied.
  - credit_cnt = 0 (width $clog2(CREDIT_NUM)+1).
  - m_valid_o = 0, m_data_o = 0, s_ready_o = 0.
  - A reset mid-operation drops every buffered word and forgets all credits; the receiver re-grants them after reset.
- s_ready_o:
  - Registered.
  - 1 when the FIFO holds fewer than 2 words after the current cycle's push/pop; 0 in reset.
- Push: s_valid_i & s_ready_o at a rising edge writes s_data_i into the FIFO. Words are popped strictly in order.
- Send decision (each edge): send = fifo_not_empty & (credit_cnt != 0).
  - On send: pop the head word into m_data_o and set m_valid_o = 1 for the next cycle.
  - Otherwise m_valid_o = 0 and m_data_o holds its last value.
- Credit counter update: credit_cnt_next = credit_cnt + m_credit_i - send.
  - Simultaneous credit and send leaves the count unchanged.
  - A credit arriving in cycle N can only be used by the send decision at edge N+1. No same-cycle bypass.
  - Saturation: a credit with credit_cnt == CREDIT_NUM and no send is dropped; the count stays at CREDIT_NUM.
  - Underflow cannot occur, because send requires credit_cnt != 0.
- Latency: word accepted at edge E, credit available → m_valid_o high in the cycle after edge E+1 (2 edges).
- Throughput: one word per cycle while credits and data are available, with no bubbles.
- Credit exhaustion: with credit_cnt = 0 the FIFO fills to 2 and s_ready_o drops. Words are never lost and never sent without a credit.
- m_valid_o is never high for more than one cycle per word. Back-to-back pulses mean back-to-back words.

Optional Feature:
- Macro: VR_VC_CREDIT_CHECK_EN.
- Defined:
  - credit_err_o port present; reset 0.
  - Set to 1 on any credit pulse arriving when credit_cnt == CREDIT_NUM and no send occurs that cycle; sticky until reset.
  - Simulation assertion also fires when m_valid_o rises with credit_cnt == 0 before the send.
- Undefined:
  - No port, no assertion.
  - Excess credits are silently dropped (saturation behaviour above is unchanged).

Test Plan:
- Reset, then 2 credit pulses, then push 0xA1 → m_valid_o pulses once with 0xA1 two edges after the push; credit_cnt goes 2→1.
- No credits, push 0x11, 0x22, 0x33 → 0x11 and 0x22 accepted; s_ready_o = 0 on the third; m_valid_o stays 0. Then 1 credit → exactly 0x11 sent; s_ready_o returns to 1 and 0x33 is accepted.
- CREDIT_NUM=2; credit pulses every cycle; stream 0x01..0x08 at full rate → eight consecutive m_valid_o pulses in order, no bubbles after the first word.
- credit_cnt=1, credit pulse in the same cycle as a send → count stays 1; next word is sent the following cycle.
- credit_cnt=2, third credit with no send → count stays 2; with VR_VC_CREDIT_CHECK_EN, credit_err_o = 1 and stays 1 until rst_n is asserted.
- Assert rst_n low asynchronously with 2 words buffered and count 1 → m_valid_o, s_ready_o and credit_cnt are 0 immediately. No buffered word is emitted after release until new credits and data arrive.
